// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port (if_*) and the load/store port (ds_*).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed ds priority with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ds_req,
    input  logic                  ds_we,
    input  logic [ADDR_W-1:0]     ds_addr,
    input  logic [DATA_W-1:0]     ds_wdata,
    input  logic [DATA_W/8-1:0]   ds_be,
    output logic                  ds_gnt,
    output logic                  ds_rvalid,
    output logic [DATA_W-1:0]     ds_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic [1:0]            o_dbg_state
);

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DS   = 2'd2
    } owner_t;

    state_t              r_state;
    owner_t              r_owner;
    logic [3:0]          r_lat_cnt;
    logic                r_is_write;
    logic                r_if_rvalid;
    logic                r_ds_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ds_rdata;

    logic                w_can_grant;
    logic                w_ds_wins;
    logic                w_gnt_if;
    logic                w_gnt_ds;
    logic                w_lat_done;

    // Grants are only issued from IDLE or RESP; a reset cycle never issues one.
    assign w_can_grant = !reset && ((r_state == S_IDLE) || (r_state == S_RESP));
    assign w_lat_done  = (r_lat_cnt == LAT_LAST);

`ifdef MEM_ARB_RR_EN
    logic r_last_ds;

    assign w_ds_wins = !r_last_ds;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ds <= 1'b0;
        end else if (w_gnt_ds) begin
            r_last_ds <= 1'b1;
        end else if (w_gnt_if) begin
            r_last_ds <= 1'b0;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] r_starve_cnt;

    assign w_ds_wins = (r_starve_cnt != STARVE_LIM);

    // Counts data grants that bypassed a waiting fetch; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 8'd0;
        end else if (w_gnt_if || (w_gnt_ds && !if_req)) begin
            r_starve_cnt <= 8'd0;
        end else if (w_gnt_ds && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`endif

    assign w_gnt_ds = w_can_grant && ds_req && (!if_req || w_ds_wins);
    assign w_gnt_if = w_can_grant && if_req && !w_gnt_ds;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_NONE;
            r_lat_cnt   <= 4'd0;
            r_is_write  <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ds_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ds_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_ds_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ds_rdata  <= '0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_gnt_if || w_gnt_ds) begin
                        r_state    <= S_WAIT;
                        r_lat_cnt  <= 4'd0;
                        r_owner    <= w_gnt_ds ? OWN_DS : OWN_IF;
                        r_is_write <= w_gnt_ds && ds_we;
                    end else begin
                        r_state    <= S_IDLE;
                        r_owner    <= OWN_NONE;
                        r_is_write <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_lat_done) begin
                        // mem_rdata is valid in this cycle; register it for the owner only.
                        r_state <= S_RESP;
                        if (r_owner == OWN_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_rdata;
                        end else if (r_owner == OWN_DS) begin
                            r_ds_rvalid <= 1'b1;
                            r_ds_rdata  <= r_is_write ? '0 : mem_rdata;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    assign if_gnt      = w_gnt_if;
    assign ds_gnt      = w_gnt_ds;
    assign mem_en      = w_gnt_if || w_gnt_ds;
    assign mem_we      = w_gnt_ds && ds_we;
    assign mem_addr    = w_gnt_ds ? ds_addr : (w_gnt_if ? if_addr : '0);
    assign mem_wdata   = mem_we ? ds_wdata : '0;
    assign mem_be      = mem_we ? ds_be : '0;

    assign if_rvalid   = r_if_rvalid;
    assign if_rdata    = r_if_rdata;
    assign ds_rvalid   = r_ds_rvalid;
    assign ds_rdata    = r_ds_rdata;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=3): directed vectors, corner sequences, randomized run vs model.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;
    localparam int N_RAND     = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ds_req;
    logic        ds_we;
    logic [31:0] ds_addr;
    logic [31:0] ds_wdata;
    logic [3:0]  ds_be;
    logic        ds_gnt;
    logic        ds_rvalid;
    logic [31:0] ds_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ds_req(ds_req), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
        .ds_be(ds_be), .ds_gnt(ds_gnt), .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy), .o_dbg_state(dbg_state)
    );

    // Memory model: contents in an associative array, reads delayed MEM_LAT cycles, junk otherwise.
    logic [31:0] tb_mem  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] rd_pipe [MEM_LAT];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] tb_rd(input logic [31:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : mem_default(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) tb_mem[mem_addr] = merge_be(tb_rd(mem_addr), mem_wdata, mem_be);
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && !mem_we) ? tb_rd(mem_addr) : $urandom();
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_addr  = '0;
        ds_req   = 1'b0;
        ds_we    = 1'b0;
        ds_addr  = '0;
        ds_wdata = '0;
        ds_be    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_gnt"},    32'(if_gnt),    32'd0);
        chk({tag, "_ds_gnt"},    32'(ds_gnt),    32'd0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, "_ds_rvalid"}, 32'(ds_rvalid), 32'd0);
        chk({tag, "_if_rdata"},  if_rdata,       32'd0);
        chk({tag, "_ds_rdata"},  ds_rdata,       32'd0);
        chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    typedef struct {
        logic        is_ds;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        preload;
        logic [31:0] pre_val;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        is_ds;
        logic [31:0] data;
    } resp_t;

    resp_t rq[$];
    int    m_free, m_busy_from, m_busy_to, m_starve;
    logic  m_last_ds;

    initial begin
        vec_t  vecs [7];
        logic  exp_ord [8];
        logic  got_ord [8];
        int    got_cyc [8];
        int    n_gnt;
        string tag;

        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
        do_reset();
        @(negedge clk);
        check_all_zero("reset");

        // Single-access vectors; ds write/read pairs verify byte enables through the RAM model.
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          4'hF, 1'b1, 32'hDEAD_BEEF,
                    1'b0, 32'h0,          4'h0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'b0011, 1'b1, 32'h1122_3344,
                    1'b1, 32'hCAFE_F00D, 4'b0011, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,
                    1'b0, 32'h0,          4'h0, 32'h1122_F00D};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_2004, 32'h9988_7766, 4'b1000, 1'b0, 32'h0,
                    1'b1, 32'h9988_7766, 4'b1000, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_2004, 32'h0,          4'h0, 1'b0, 32'h0,
                    1'b0, 32'h0,          4'h0, 32'h9922_F00D};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0000, 1'b0, 32'h0,
                    1'b1, 32'h1234_5678, 4'b0000, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_2004, 32'h0,          4'h0, 1'b0, 32'h0,
                    1'b0, 32'h0,          4'h0, 32'h9922_F00D};

        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("vec%0d", v);
            if (vecs[v].preload) tb_mem[vecs[v].addr] = vecs[v].pre_val;
            tick();
            if (vecs[v].is_ds) begin
                ds_req = 1'b1; ds_we = vecs[v].we; ds_addr = vecs[v].addr;
                ds_wdata = vecs[v].wdata; ds_be = vecs[v].be;
            end else begin
                if_req = 1'b1; if_addr = vecs[v].addr;
                ds_wdata = $urandom(); ds_be = 4'hF; ds_we = 1'b1;
            end
            @(negedge clk);
            chk({tag, "_if_gnt"},    32'(if_gnt),  32'(!vecs[v].is_ds));
            chk({tag, "_ds_gnt"},    32'(ds_gnt),  32'(vecs[v].is_ds));
            chk({tag, "_mem_en"},    32'(mem_en),  32'd1);
            chk({tag, "_mem_addr"},  mem_addr,     vecs[v].addr);
            chk({tag, "_mem_we"},    32'(mem_we),  32'(vecs[v].exp_we));
            chk({tag, "_mem_wdata"}, mem_wdata,    vecs[v].exp_wdata);
            chk({tag, "_mem_be"},    32'(mem_be),  32'(vecs[v].exp_be));
            for (int k = 1; k <= 4; k++) begin
                tick();
                idle_inputs();
                @(negedge clk);
                if (k == 3) begin
                    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'(!vecs[v].is_ds));
                    chk({tag, "_ds_rvalid"}, 32'(ds_rvalid), 32'(vecs[v].is_ds));
                    chk({tag, "_if_rdata"},  if_rdata, vecs[v].is_ds ? 32'h0 : vecs[v].exp_rdata);
                    chk({tag, "_ds_rdata"},  ds_rdata, vecs[v].is_ds ? vecs[v].exp_rdata : 32'h0);
                    chk({tag, "_busy_resp"}, 32'(busy), 32'd1);
                end else begin
                    chk($sformatf("%s_rvalid_c%0d", tag, k), 32'({if_rvalid, ds_rvalid}), 32'd0);
                    chk($sformatf("%s_mem_en_c%0d", tag, k), 32'(mem_en), 32'd0);
                end
                if (k == 4) chk({tag, "_busy_done"}, 32'(busy), 32'd0);
            end
        end

        // Both ports requesting continuously.
`ifdef MEM_ARB_RR_EN
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        do_reset();
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0400;
        ds_req = 1'b1; ds_we = 1'b0; ds_addr = 32'h0000_0800;
        n_gnt = 0;
        for (int k = 0; k < 40 && n_gnt < 8; k++) begin
            @(negedge clk);
            if (if_gnt || ds_gnt) begin
                got_ord[n_gnt] = ds_gnt;
                got_cyc[n_gnt] = k;
                n_gnt++;
            end
            tick();
        end
        chk("arb_grant_count", 32'(n_gnt), 32'd8);
        for (int i = 0; i < n_gnt; i++) begin
            chk($sformatf("arb_order_%0d", i), 32'(got_ord[i]), 32'(exp_ord[i]));
            if (i > 0) chk($sformatf("arb_spacing_%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'(MEM_LAT + 1));
        end
        idle_inputs();
        for (int k = 0; k < MEM_LAT + 2; k++) tick();

        // Reset one cycle after a grant drops the response.
        do_reset();
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk);
        chk("rstmid_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rstmid_busy_c1", 32'(busy), 32'd1);
        tick();
        reset = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check_all_zero($sformatf("rstmid_c%0d", k));
            tick();
        end

        // A one-cycle ds pulse while busy is never served.
        do_reset();
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0080;
        @(negedge clk);
        chk("pulse_if_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0;
        ds_req = 1'b1; ds_we = 1'b1; ds_addr = 32'h0000_0500; ds_wdata = 32'h5555_AAAA; ds_be = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("pulse_ds_gnt_c%0d", k), 32'(ds_gnt), 32'd0);
            chk($sformatf("pulse_mem_en_c%0d", k), 32'(mem_en), 32'd0);
            chk($sformatf("pulse_ds_rvalid_c%0d", k), 32'(ds_rvalid), 32'd0);
            if (k == 3) chk("pulse_if_rvalid", 32'(if_rvalid), 32'd1);
            tick();
            idle_inputs();
        end

        // Randomized traffic against a free-cycle / queue reference model.
        do_reset();
        m_free = 0; m_busy_from = 0; m_busy_to = -1; m_starve = 0; m_last_ds = 1'b0;
        rq.delete();
        for (int c = 0; c < N_RAND + MEM_LAT + 4; c++) begin
            logic  e_if_gnt, e_ds_gnt, e_busy, e_if_rv, e_ds_rv, pick_ds;
            logic [31:0] e_addr, e_wdata, e_if_rd, e_ds_rd;
            logic [3:0]  e_be;
            logic  e_we;
            resp_t r;
            tick();
            if (c < N_RAND) begin
                if_req   = ($urandom_range(0, 99) < 55);
                if_addr  = 32'h3000 + 32'(4 * $urandom_range(0, 7));
                ds_req   = ($urandom_range(0, 99) < 60);
                ds_we    = ($urandom_range(0, 2) == 0);
                ds_addr  = 32'h3000 + 32'(4 * $urandom_range(0, 7));
                ds_wdata = $urandom();
                ds_be    = 4'($urandom_range(0, 15));
                reset    = ($urandom_range(0, 99) < 2);
            end else begin
                idle_inputs();
                reset = 1'b0;
            end

            e_busy = (c >= m_busy_from) && (c <= m_busy_to);
            e_if_rv = 1'b0; e_ds_rv = 1'b0; e_if_rd = '0; e_ds_rd = '0;
            if (rq.size() > 0 && rq[0].cyc == c) begin
                r = rq.pop_front();
                if (r.is_ds) begin e_ds_rv = 1'b1; e_ds_rd = r.data; end
                else begin e_if_rv = 1'b1; e_if_rd = r.data; end
            end

            e_if_gnt = 1'b0; e_ds_gnt = 1'b0; e_we = 1'b0;
            e_addr = '0; e_wdata = '0; e_be = '0;
            if (!reset && c >= m_free && (if_req || ds_req)) begin
`ifdef MEM_ARB_RR_EN
                pick_ds = ds_req && (!if_req || !m_last_ds);
`else
                pick_ds = ds_req && (!if_req || m_starve < STARVE_MAX);
`endif
                e_ds_gnt = pick_ds;
                e_if_gnt = !pick_ds;
                if (pick_ds) begin
                    m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                    e_addr = ds_addr;
                    if (ds_we) begin
                        e_we = 1'b1; e_wdata = ds_wdata; e_be = ds_be;
                        ref_mem[ds_addr] = merge_be(ref_rd(ds_addr), ds_wdata, ds_be);
                        rq.push_back('{c + MEM_LAT + 1, 1'b1, 32'h0});
                    end else begin
                        rq.push_back('{c + MEM_LAT + 1, 1'b1, ref_rd(ds_addr)});
                    end
                end else begin
                    m_starve = 0;
                    e_addr = if_addr;
                    rq.push_back('{c + MEM_LAT + 1, 1'b0, ref_rd(if_addr)});
                end
                m_last_ds   = pick_ds;
                m_free      = c + MEM_LAT + 1;
                m_busy_from = c + 1;
                m_busy_to   = c + MEM_LAT + 1;
            end
            if (reset) begin
                rq.delete();
                m_free = c + 1; m_busy_to = c; m_starve = 0; m_last_ds = 1'b0;
            end

            @(negedge clk);
            chk($sformatf("rnd_if_gnt@%0d", c),    32'(if_gnt),    32'(e_if_gnt));
            chk($sformatf("rnd_ds_gnt@%0d", c),    32'(ds_gnt),    32'(e_ds_gnt));
            chk($sformatf("rnd_mem_en@%0d", c),    32'(mem_en),    32'(e_if_gnt || e_ds_gnt));
            chk($sformatf("rnd_busy@%0d", c),      32'(busy),      32'(e_busy));
            chk($sformatf("rnd_if_rvalid@%0d", c), 32'(if_rvalid), 32'(e_if_rv));
            chk($sformatf("rnd_ds_rvalid@%0d", c), 32'(ds_rvalid), 32'(e_ds_rv));
            if (e_if_gnt || e_ds_gnt) begin
                chk($sformatf("rnd_mem_addr@%0d", c),  mem_addr,     e_addr);
                chk($sformatf("rnd_mem_we@%0d", c),    32'(mem_we),  32'(e_we));
                chk($sformatf("rnd_mem_wdata@%0d", c), mem_wdata,    e_wdata);
                chk($sformatf("rnd_mem_be@%0d", c),    32'(mem_be),  32'(e_be));
            end
            if (e_if_rv || e_ds_rv) begin
                chk($sformatf("rnd_if_rdata@%0d", c), if_rdata, e_if_rd);
                chk($sformatf("rnd_ds_rdata@%0d", c), ds_rdata, e_ds_rd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
